// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU/EX, B = MEM/load),
// the arbiter, and the register file write port / hazard logic.
interface reg_file_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Requester A
    logic                     a_valid;
    logic [ADDR_W-1:0]        a_addr;
    logic [DATA_W-1:0]        a_data;
    logic                     a_ready;
    // Requester B
    logic                     b_valid;
    logic [ADDR_W-1:0]        b_addr;
    logic [DATA_W-1:0]        b_data;
    logic                     b_ready;
    // Register file write port and hazard mask
    logic                     write;
    logic [ADDR_W-1:0]        WR;
    logic [DATA_W-1:0]        WD;
    logic                     grant_b;
    logic [(1<<ADDR_W)-1:0]   pending_mask;

    // Requester / consumer side
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write, WR, WD, grant_b, pending_mask
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write, WR, WD, grant_b, pending_mask
    );
endinterface

// File: rtl/reg_file_wb_arbiter.sv
// Two-requester writeback arbiter for a single-write-port register file.
// Each side has a one-entry buffer; buffers drain round-robin, except that
// two entries for the same register drain oldest-first so the younger value
// is what remains in the register file.
module reg_file_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,   // async, active low
    input  logic                 flush,
    reg_file_wb_arbiter_if.slave bus
);
    // Buffer state
    logic              a_v_q, a_v_d, b_v_q, b_v_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic              last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic              a_older_q, a_older_d;

    // Derived control
    logic wr_en, gb;
    logic a_rdy, b_rdy;
    logic a_drain, b_drain;
    logic a_load, b_load;

    // State register; reset starts with last_grant = B so A wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_v_q        <= 1'b0;
            b_v_q        <= 1'b0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            a_data_q     <= '0;
            b_data_q     <= '0;
            last_grant_q <= 1'b1;
            a_older_q    <= 1'b0;
        end else begin
            a_v_q        <= a_v_d;
            b_v_q        <= b_v_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            a_data_q     <= a_data_d;
            b_data_q     <= b_data_d;
            last_grant_q <= last_grant_d;
            a_older_q    <= a_older_d;
        end
    end

    // Grant, readiness and load decisions; all depend on registered state so
    // ready never combinationally follows valid
    always_comb begin
        wr_en = a_v_q | b_v_q;
        gb    = 1'b0;
        if (a_v_q && b_v_q)
            gb = (a_addr_q == b_addr_q) ? ~a_older_q : ~last_grant_q;
        else if (b_v_q)
            gb = 1'b1;
        a_drain = wr_en & ~gb;
        b_drain = wr_en &  gb;
        a_rdy   = ~a_v_q | a_drain;
        b_rdy   = ~b_v_q | b_drain;
        // Writes to r0 complete the handshake but are never buffered
        a_load  = bus.a_valid & a_rdy & ~flush & !(DROP_R0 && (bus.a_addr == '0));
        b_load  = bus.b_valid & b_rdy & ~flush & !(DROP_R0 && (bus.b_addr == '0));
    end

    // Next-state: drain the granted buffer, refill on handshake, track age
    always_comb begin
        a_v_d        = a_v_q;
        b_v_d        = b_v_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        a_data_d     = a_data_q;
        b_data_d     = b_data_q;
        last_grant_d = last_grant_q;
        a_older_d    = a_older_q;
        if (flush) begin
            // The current write still reaches the reg file; everything buffered is dropped
            a_v_d     = 1'b0;
            b_v_d     = 1'b0;
            a_older_d = 1'b0;
        end else begin
            if (a_drain) a_v_d = 1'b0;
            if (b_drain) b_v_d = 1'b0;
            if (a_load) begin
                a_v_d    = 1'b1;
                a_addr_d = bus.a_addr;
                a_data_d = bus.a_data;
            end
            if (b_load) begin
                b_v_d    = 1'b1;
                b_addr_d = bus.b_addr;
                b_data_d = bus.b_data;
            end
            if (wr_en) last_grant_d = gb;
            // Same-edge loads: MEM carries the older instruction.
            // Single load: it is younger only if the other side keeps a live entry.
            if (a_load && b_load)
                a_older_d = 1'b0;
            else if (a_load)
                a_older_d = ~(b_v_q & ~b_drain);
            else if (b_load)
                a_older_d = a_v_q & ~a_drain;
        end
    end

    // Outputs: write port fields from the granted buffer, pending-write mask
    always_comb begin
        bus.a_ready      = a_rdy;
        bus.b_ready      = b_rdy;
        bus.write        = wr_en;
        bus.grant_b      = gb;
        bus.WR           = '0;
        bus.WD           = '0;
        if (wr_en) begin
            bus.WR = gb ? b_addr_q : a_addr_q;
            bus.WD = gb ? b_data_q : a_data_q;
        end
        bus.pending_mask = '0;
        if (a_v_q) bus.pending_mask[a_addr_q] = 1'b1;
        if (b_v_q) bus.pending_mask[b_addr_q] = 1'b1;
    end
endmodule
